// File: rtl/io_port_responder.sv
// CPU-facing register port that bridges a request/acknowledge bus to an input
// FIFO (external producer -> CPU) and an output FIFO (CPU -> external consumer).
// Blocked DATA accesses wait in BUSY until the FIFO allows them or the wait
// counter reaches TIMEOUT, which acknowledges with io_err set.
module io_port_responder #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_req,
  input  logic        io_we,
  input  logic [1:0]  io_addr,
  input  logic [15:0] io_wdata,
  output logic        io_ack,
  output logic [15:0] io_rdata,
  output logic        io_err,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_COUNT  = 2'd3;

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t          state, state_next;
  logic [7:0]      wait_cnt;
  logic [1:0]      ctrl;
  logic [15:0]     rdata_q;
  logic            err_q;

  logic [15:0]     in_mem  [FIFO_DEPTH];
  logic [PW-1:0]   in_wr_ptr, in_rd_ptr;
  logic [CW-1:0]   in_count;
  logic [15:0]     out_mem [FIFO_DEPTH];
  logic [PW-1:0]   out_wr_ptr, out_rd_ptr;
  logic [CW-1:0]   out_count;

  logic in_full, in_empty, out_full, out_empty;
  logic blocked, timeout_hit, complete;
  logic in_push, in_pop, out_push, out_pop;
  logic [15:0] rd_mux;

  assign in_full   = (in_count == CW'(FIFO_DEPTH));
  assign in_empty  = (in_count == '0);
  assign out_full  = (out_count == CW'(FIFO_DEPTH));
  assign out_empty = (out_count == '0);

  // Blocking is judged on the registered counts, so a push or pop at the same
  // edge only helps a waiting access one edge later.
  assign blocked     = (state == BUSY) && (io_addr == ADDR_DATA) &&
                       (io_we ? out_full : in_empty);
  assign timeout_hit = blocked && (wait_cnt == 8'(TIMEOUT - 1));
  assign complete    = (state == BUSY) && !blocked;

  assign in_pop   = complete && (io_addr == ADDR_DATA) && !io_we;
  assign out_push = complete && (io_addr == ADDR_DATA) && io_we;
  // CTRL resets to 2'b11, so in_ready is gated by reset to stay low while it
  // is held and rise in the first cycle after release.
  assign in_ready  = !reset && !in_full && ctrl[0];
  assign out_valid = !out_empty && ctrl[1];
  assign in_push   = in_valid && in_ready;
  assign out_pop   = out_valid && out_ready;
  assign out_data  = out_empty ? 16'h0000 : out_mem[out_rd_ptr];

  assign io_ack   = (state == ACK);
  assign io_rdata = (state == ACK) ? rdata_q : 16'h0000;
  assign io_err   = (state == ACK) && err_q;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; io_req is only looked at in IDLE.
  // NOTE: defaults are assigned first so no path leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (io_req) state_next = BUSY;
      BUSY:    if (complete || timeout_hit) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Register read multiplexer.
  always_comb begin
    rd_mux = 16'h0000;
    case (io_addr)
      ADDR_DATA:   rd_mux = in_mem[in_rd_ptr];
      ADDR_STATUS: rd_mux = {12'h000, out_full, out_empty, in_full, in_empty};
      ADDR_CTRL:   rd_mux = {14'h0000, ctrl};
      ADDR_COUNT:  rd_mux = {3'b000, 5'(out_count), 3'b000, 5'(in_count)};
      default:     rd_mux = 16'h0000;
    endcase
  end

  // Wait counter, CTRL register and captured response.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      ctrl     <= 2'b11;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == IDLE && io_req) wait_cnt <= '0;
      else if (blocked)            wait_cnt <= wait_cnt + 8'd1;
      if (complete) begin
        rdata_q <= io_we ? 16'h0000 : rd_mux;
        err_q   <= 1'b0;
        if (io_we && io_addr == ADDR_CTRL) ctrl <= io_wdata[1:0];
      end else if (timeout_hit) begin
        rdata_q <= 16'h0000;
        err_q   <= 1'b1;
      end
    end
  end

  // FIFO storage writes.
  // NOTE: the storage arrays are not reset; the counts and pointers alone define validity.
  always_ff @(posedge clock) begin
    if (in_push)  in_mem[in_wr_ptr]   <= in_data;
    if (out_push) out_mem[out_wr_ptr] <= io_wdata;
  end

  // FIFO pointers and occupancy counts; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_wr_ptr  <= '0;
      in_rd_ptr  <= '0;
      in_count   <= '0;
      out_wr_ptr <= '0;
      out_rd_ptr <= '0;
      out_count  <= '0;
    end else begin
      if (in_push)  in_wr_ptr  <= in_wr_ptr + 1'b1;
      if (in_pop)   in_rd_ptr  <= in_rd_ptr + 1'b1;
      if (out_push) out_wr_ptr <= out_wr_ptr + 1'b1;
      if (out_pop)  out_rd_ptr <= out_rd_ptr + 1'b1;
      case ({in_push, in_pop})
        2'b10:   in_count <= in_count + 1'b1;
        2'b01:   in_count <= in_count - 1'b1;
        default: in_count <= in_count;
      endcase
      case ({out_push, out_pop})
        2'b10:   out_count <= out_count + 1'b1;
        2'b01:   out_count <= out_count - 1'b1;
        default: out_count <= out_count;
      endcase
    end
  end

endmodule

// File: tb/tb_io_port_responder.sv
// Directed bench for io_port_responder with default parameters
// (FIFO_DEPTH = 4, TIMEOUT = 255).
module tb_io_port_responder;

  localparam logic [1:0] DATA   = 2'd0;
  localparam logic [1:0] STATUS = 2'd1;
  localparam logic [1:0] CTRL   = 2'd2;
  localparam logic [1:0] COUNT  = 2'd3;
  localparam int         BOUND  = 400;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_req, io_we;
  logic [1:0]  io_addr;
  logic [15:0] io_wdata;
  logic        io_ack;
  logic [15:0] io_rdata;
  logic        io_err;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;

  int passed = 0;
  int total  = 0;

  io_port_responder dut (
    .clock    (clock),
    .reset    (reset),
    .io_req   (io_req),
    .io_we    (io_we),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_ack   (io_ack),
    .io_rdata (io_rdata),
    .io_err   (io_err),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_req(input logic we, input logic [1:0] addr, input logic [15:0] wdata);
    io_req   = 1'b1;
    io_we    = we;
    io_addr  = addr;
    io_wdata = wdata;
  endtask

  task automatic end_req();
    io_req = 1'b0;
    io_we  = 1'b0;
    tick();
  endtask

  // Full access: returns captured response and the number of edges to io_ack
  // (BOUND means io_ack never came).
  task automatic access(input logic we, input logic [1:0] addr, input logic [15:0] wdata,
                        output logic [15:0] rdata, output logic err, output int cycles);
    start_req(we, addr, wdata);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!io_ack && cycles < BOUND);
    rdata = io_rdata;
    err   = io_err;
    end_req();
  endtask

  task automatic push_in(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  logic [15:0] rd;
  logic        er;
  int          cyc;
  logic [15:0] exp_words [4];

  initial begin
    reset = 1'b1;
    io_req = 1'b0; io_we = 1'b0; io_addr = 2'd0; io_wdata = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Outputs while reset is held.
    repeat (2) tick();
    check("rst_ack",       {15'd0, io_ack},    16'h0000);
    check("rst_err",       {15'd0, io_err},    16'h0000);
    check("rst_rdata",     io_rdata,           16'h0000);
    check("rst_out_valid", {15'd0, out_valid}, 16'h0000);
    check("rst_out_data",  out_data,           16'h0000);
    check("rst_in_ready",  {15'd0, in_ready},  16'h0000);
    reset = 1'b0;
    tick();
    check("post_rst_in_ready", {15'd0, in_ready}, 16'h0001);

    // Basic pushed word read back through DATA.
    push_in(16'h1234);
    access(1'b0, DATA, 16'h0, rd, er, cyc);
    check("rd_data_cycles", 16'(cyc), 16'd2);
    check("rd_data_val",    rd,       16'h1234);
    check("rd_data_err",    {15'd0, er}, 16'h0000);
    access(1'b0, COUNT, 16'h0, rd, er, cyc);
    check("count_after_rd", rd, 16'h0000);
    access(1'b0, STATUS, 16'h0, rd, er, cyc);
    check("status_empty", rd, 16'h0005);
    access(1'b0, CTRL, 16'h0, rd, er, cyc);
    check("ctrl_reset_val", rd, 16'h0003);

    // Fill the output FIFO, then a fifth write blocks until a pop frees space.
    for (int i = 0; i < 4; i++) begin
      access(1'b1, DATA, 16'hBEEF, rd, er, cyc);
      check("wr_data_cycles", 16'(cyc), 16'd2);
    end
    access(1'b0, COUNT, 16'h0, rd, er, cyc);
    check("count_out_full", rd, 16'h0400);
    access(1'b0, STATUS, 16'h0, rd, er, cyc);
    check("status_out_full", rd, 16'h0009);
    check("out_head_beef", out_data, 16'hBEEF);
    start_req(1'b1, DATA, 16'hCAFE);
    repeat (5) tick();
    check("blocked_wr_no_ack", {15'd0, io_ack}, 16'h0000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pop_edge_no_ack", {15'd0, io_ack}, 16'h0000);
    tick();
    check("blocked_wr_ack", {15'd0, io_ack}, 16'h0001);
    check("blocked_wr_err", {15'd0, io_err}, 16'h0000);
    end_req();
    access(1'b0, COUNT, 16'h0, rd, er, cyc);
    check("count_after_unblock", rd, 16'h0400);
    exp_words[0] = 16'hBEEF; exp_words[1] = 16'hBEEF;
    exp_words[2] = 16'hBEEF; exp_words[3] = 16'hCAFE;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_out_word", out_data, exp_words[i]);
      tick();
    end
    out_ready = 1'b0;
    check("drained_out_valid", {15'd0, out_valid}, 16'h0000);
    check("drained_out_data",  out_data,           16'h0000);

    // Fill the input FIFO; a pop while the producer keeps pushing refills it.
    push_in(16'h00A1); push_in(16'h00A2); push_in(16'h00A3); push_in(16'h00A4);
    check("in_full_ready", {15'd0, in_ready}, 16'h0000);
    access(1'b0, STATUS, 16'h0, rd, er, cyc);
    check("status_in_full", rd, 16'h0006);
    in_valid = 1'b1;
    in_data  = 16'h00A5;
    access(1'b0, DATA, 16'h0, rd, er, cyc);
    in_valid = 1'b0;
    check("rd_full_head", rd, 16'h00A1);
    access(1'b0, COUNT, 16'h0, rd, er, cyc);
    check("count_refilled", rd, 16'h0004);
    exp_words[0] = 16'h00A2; exp_words[1] = 16'h00A3;
    exp_words[2] = 16'h00A4; exp_words[3] = 16'h00A5;
    for (int i = 0; i < 4; i++) begin
      access(1'b0, DATA, 16'h0, rd, er, cyc);
      check("drain_in_word", rd, exp_words[i]);
    end

    // A push into the empty FIFO satisfies a blocked read one edge later.
    start_req(1'b0, DATA, 16'h0);
    repeat (3) tick();
    in_valid = 1'b1;
    in_data  = 16'h5A5A;
    tick();
    in_valid = 1'b0;
    check("push_edge_no_ack", {15'd0, io_ack}, 16'h0000);
    tick();
    check("late_rd_ack",   {15'd0, io_ack}, 16'h0001);
    check("late_rd_rdata", io_rdata,        16'h5A5A);
    end_req();

    // CTRL enables gate the streaming sides without losing contents.
    access(1'b1, DATA, 16'h1111, rd, er, cyc);
    check("out_valid_on", {15'd0, out_valid}, 16'h0001);
    access(1'b1, CTRL, 16'h0001, rd, er, cyc);
    out_ready = 1'b1;
    tick();
    check("out_valid_off", {15'd0, out_valid}, 16'h0000);
    out_ready = 1'b0;
    access(1'b0, COUNT, 16'h0, rd, er, cyc);
    check("out_retained", rd, 16'h0100);
    access(1'b1, CTRL, 16'h0003, rd, er, cyc);
    check("out_valid_again", {15'd0, out_valid}, 16'h0001);
    check("out_head_same",   out_data,           16'h1111);
    access(1'b1, CTRL, 16'h0002, rd, er, cyc);
    check("in_ready_off", {15'd0, in_ready}, 16'h0000);
    access(1'b1, CTRL, 16'hFFFF, rd, er, cyc);
    access(1'b0, CTRL, 16'h0, rd, er, cyc);
    check("ctrl_upper_zero", rd, 16'h0003);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Writes to read-only registers are acknowledged cleanly and ignored.
    access(1'b1, STATUS, 16'hFFFF, rd, er, cyc);
    check("wr_status_cycles", 16'(cyc),    16'd2);
    check("wr_status_err",    {15'd0, er}, 16'h0000);
    access(1'b0, STATUS, 16'h0, rd, er, cyc);
    check("status_unchanged", rd, 16'h0005);

    // Blocked read with nothing arriving runs into the timeout.
    access(1'b0, DATA, 16'h0, rd, er, cyc);
    check("timeout_cycles", 16'(cyc),    16'd256);
    check("timeout_err",    {15'd0, er}, 16'h0001);
    check("timeout_rdata",  rd,          16'h0000);
    check("idle_err_low",   {15'd0, io_err}, 16'h0000);

    // Reset during a blocked read abandons it and restores defaults.
    access(1'b1, DATA, 16'h2222, rd, er, cyc);
    access(1'b1, CTRL, 16'h0001, rd, er, cyc);
    start_req(1'b0, DATA, 16'h0);
    repeat (3) tick();
    reset = 1'b1;
    #2;
    check("mid_rst_ack", {15'd0, io_ack}, 16'h0000);
    io_req = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abandoned_no_ack", {15'd0, io_ack}, 16'h0000);
    end
    access(1'b0, COUNT, 16'h0, rd, er, cyc);
    check("rst_count_zero", rd, 16'h0000);
    access(1'b0, CTRL, 16'h0, rd, er, cyc);
    check("rst_ctrl_val", rd, 16'h0003);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
